// File: rtl/mux_n_pipe_if.sv
// Bus bundle for mux_n_pipe: packed data inputs, select, and the in/out handshakes.
interface mux_n_pipe_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned NUM_IN = 7
);
  localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN*N-1:0] D;
  logic [SEL_W-1:0]    sel;
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        Y;
  logic                out_err;
  logic                out_valid;
  logic                out_ready;
  logic                flush;
  logic                err_clr;
  logic                sel_err;

  // Upstream/downstream agent side
  modport master (
    output D, sel, in_valid, out_ready, flush, err_clr,
    input  in_ready, Y, out_err, out_valid, sel_err
  );

  // Mux block side
  modport slave (
    input  D, sel, in_valid, out_ready, flush, err_clr,
    output in_ready, Y, out_err, out_valid, sel_err
  );
endinterface

// File: rtl/mux_n_pipe.sv
// N-input mux with a two-entry (head + skid) valid/ready output buffer and
// a sticky out-of-range-select error flag.
module mux_n_pipe #(
  parameter int unsigned N      = 32,
  parameter int unsigned NUM_IN = 7
) (
  input logic          clk,
  input logic          rst,
  mux_n_pipe_if.slave  bus
);
  localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   head_q, head_d;
  logic           head_err_q, head_err_d;
  logic [N-1:0]   skid_q, skid_d;
  logic           skid_err_q, skid_err_d;
  logic           sel_err_q, sel_err_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic [N-1:0]   new_data;
  logic           new_err;
  logic           in_xfer;
  logic           out_xfer;

  // Select the addressed input; an index past NUM_IN yields zero data with the error bit
  always_comb begin
    new_data = '0;
    new_err  = 1'b1;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (32'(bus.sel) == i) begin
        new_data = bus.D[i*N +: N];
        new_err  = 1'b0;
      end
    end
  end

  // Next-state, buffer moves and sticky error update
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    head_err_d = head_err_q;
    skid_d     = skid_q;
    skid_err_d = skid_err_q;

    in_xfer  = bus.in_valid && in_ready_q && !bus.flush;
    out_xfer = out_valid_q && bus.out_ready;

    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          head_d     = new_data;
          head_err_d = new_err;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer) begin
          if (out_xfer) begin
            head_d     = new_data;
            head_err_d = new_err;
          end else begin
            skid_d     = new_data;
            skid_err_d = new_err;
            state_d    = FULL;
          end
        end else if (out_xfer) begin
          // Keep Y at zero whenever nothing is buffered
          head_d     = '0;
          head_err_d = 1'b0;
          state_d    = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          head_d     = skid_q;
          head_err_d = skid_err_q;
          skid_d     = '0;
          skid_err_d = 1'b0;
          state_d    = BUSY;
        end
      end
      default: begin
        head_d     = '0;
        head_err_d = 1'b0;
        skid_d     = '0;
        skid_err_d = 1'b0;
        state_d    = EMPTY;
      end
    endcase

    // Flush drops everything buffered, including any entry offered this cycle
    if (bus.flush) begin
      head_d     = '0;
      head_err_d = 1'b0;
      skid_d     = '0;
      skid_err_d = 1'b0;
      state_d    = EMPTY;
    end

    // A new error wins over a clear in the same cycle
    sel_err_d   = (in_xfer && new_err) || (sel_err_q && !bus.err_clr);
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // State and buffer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      head_err_q  <= 1'b0;
      skid_q      <= '0;
      skid_err_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      head_err_q  <= head_err_d;
      skid_q      <= skid_d;
      skid_err_q  <= skid_err_d;
      sel_err_q   <= sel_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Y         = head_q;
  assign bus.out_err   = head_err_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: doc/mux_n_pipe.md
MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 Parameter N, default 32, data width of each input and of the output.
REQ-002 Parameter NUM_IN, default 7, number of data inputs; legal range 2..64.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN), select width; derived, never overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 D  input  NUM_IN*N  packed data inputs; input i occupies bits [i*N +: N].
REQ-007 sel  input  SEL_W  input index to forward, sampled with in_valid.
REQ-008 in_valid  input  1  upstream presents D/sel this cycle.
REQ-009 in_ready  output  1  block can accept a transfer this cycle.
REQ-010 Y  output  N  selected data of the head entry.
REQ-011 out_err  output  1  head entry was produced by an out-of-range sel.
REQ-012 out_valid  output  1  Y/out_err hold a valid entry.
REQ-013 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-014 flush  input  1  discard all buffered entries.
REQ-015 err_clr  input  1  clear the sticky error flag.
REQ-016 sel_err  output  1  sticky flag, set by any accepted out-of-range sel.

Function
REQ-017 Input transfer = in_valid && in_ready && !flush; output transfer = out_valid && out_ready.
REQ-018 Selection is evaluated at input transfer: data = D[sel*N +: N] if sel < NUM_IN, else all zeros with error bit 1.
REQ-019 Storage is a head register plus one skid register; states EMPTY (0 entries), BUSY (head only), FULL (head + skid).
REQ-020 out_valid = (state != EMPTY); in_ready = (state != FULL); both decode registered state only, with no combinational path from out_ready or in_valid.
REQ-021 EMPTY: input transfer -> head loaded, BUSY; otherwise stay.
REQ-022 BUSY: input and output transfer -> head reloaded with new entry, stay BUSY; input only -> skid loaded, FULL; output only -> EMPTY; neither -> hold.
REQ-023 FULL: output transfer -> head <= skid, BUSY; otherwise hold; no input transfer is possible.
REQ-024 Latency: entry accepted at edge k is on Y with out_valid=1 in the cycle after edge k when state was EMPTY.
REQ-025 Throughput: one entry per cycle sustained while out_ready=1; entries leave in acceptance order; none is dropped or duplicated.
REQ-026 Y and out_err hold stable while out_valid=1 and out_ready=0.
REQ-027 flush: next state EMPTY regardless of other inputs; input offered the same cycle is discarded; output transfer that cycle still counts as consumed.
REQ-028 sel_err set on the edge after an accepted out-of-range sel; err_clr clears it; simultaneous set and clear -> remains 1 (set wins).
REQ-029 flush does not affect sel_err.
REQ-030 Y is all zeros whenever state is EMPTY.

Reset
REQ-031 rst=1 at an edge: state EMPTY, head/skid data and error bits zero, sel_err=0; overrides flush, err_clr, and any transfer that cycle.
REQ-032 Outputs after reset: out_valid=0, in_ready=1, Y=0, out_err=0, sel_err=0.
REQ-033 Reset mid-operation discards all buffered entries with no partial output.

Verification
REQ-034 Reset, then D input 3 = 0xDEADBEEF, sel=3, in_valid=1 for 1 cycle, out_ready=1 -> next cycle Y=0xDEADBEEF, out_valid=1, out_err=0; following cycle out_valid=0.
REQ-035 out_ready=0, accept sel=1 then sel=2 (inputs 0x11, 0x22) -> in_ready=0 after second accept; Y=0x11 held; out_ready=1 -> Y=0x22 next cycle, in_ready=1.
REQ-036 NUM_IN=7, sel=7 accepted -> Y=0, out_err=1, sel_err=1 next cycle; err_clr=1 with a new sel=7 same cycle -> sel_err stays 1.
REQ-037 State FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, Y=0; sel_err unchanged.
REQ-038 Streaming 100 entries, sel cycling 0..6, out_ready random -> scoreboard order and values match D[sel]; no loss or duplicate.
REQ-039 rst=1 while FULL with flush=0, err_clr=0 -> next cycle all outputs at REQ-032 values.
